adc_sample_src: RTL and testbench



---
 rtl/adc_sample_src_pkg.sv | 28 ++
 rtl/axis_fifo2.sv | 72 +++++++
 rtl/adc_sample_src.sv | 154 +++++++++++++++
 tb/tb_adc_sample_src.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_src_pkg.sv
// rtl/adc_sample_src_pkg.sv - shared constants and LFSR step for the synthetic ADC sample source
package adc_sample_src_pkg;

    // Pattern select; code 3 falls through to ramp.
    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    // Fibonacci x^16+x^14+x^13+x^11+1: taps on bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Sample word layout {ch, seq, value}.
    localparam int CH_LSB  = 28;
    localparam int CH_W    = 4;
    localparam int SEQ_LSB = 16;
    localparam int SEQ_W   = 12;
    localparam int VAL_LSB = 0;
    localparam int VAL_W   = 16;

    localparam int STAT_W  = 32;

    // Shift left, XOR of tapped bits enters at bit 0; a non-zero seed never reaches 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_fifo2.sv
// rtl/axis_fifo2.sv - two-entry AXI-Stream output buffer with push/full and same-cycle push+pop when full
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (empties the buffer)
//   push, push_data     write request; accepted when not full or when a pop happens this cycle
//   full                both entries occupied
//   m_axis_tdata/tvalid head entry / non-empty
//   m_axis_tready       downstream ready; pop on tvalid && tready
module axis_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;
    logic         push_ok;

    assign full          = (cnt_q == 2'd2);
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        pop     = m_axis_tvalid && m_axis_tready;
        // When full, wr and rd point at the same slot; the head is read out
        // combinationally this cycle before the new word overwrites it.
        push_ok = push && (!full || pop);
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_src.sv
// rtl/adc_sample_src.sv - synthetic interleaved ADC sample source on an AXI-Stream master
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   ctrl_enable         run; rising edge restarts counter/ch/seq/ramp/LFSR
//   ctrl_mode           0 ramp, 1 LFSR, 2 constant, 3 ramp
//   ctrl_div            sample period minus 1 in aclk cycles
//   ctrl_step           ramp increment per tick
//   ctrl_const          constant-mode value
//   ctrl_clr            clears stat counters (wins over increments)
//   m_axis_*            sample stream {ch[3:0], seq[11:0], value[15:0]}
//   stat_sent/drop      saturating handshake / overflow counters
//   stat_busy           enabled or buffer non-empty
module adc_sample_src
    import adc_sample_src_pkg::*;
#(
    parameter int C_DIV_WIDTH = 16,
    parameter int C_NUM_CH    = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   ctrl_enable,
    input  logic [1:0]             ctrl_mode,
    input  logic [C_DIV_WIDTH-1:0] ctrl_div,
    input  logic [15:0]            ctrl_step,
    input  logic [15:0]            ctrl_const,
    input  logic                   ctrl_clr,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [STAT_W-1:0]      stat_sent,
    output logic [STAT_W-1:0]      stat_drop,
    output logic                   stat_busy
);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(C_NUM_CH - 1);

    logic                   en_q, en_d;
    logic [C_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [VAL_W-1:0]       ramp_q, ramp_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [STAT_W-1:0]      sent_q, sent_d;
    logic [STAT_W-1:0]      drop_q, drop_d;

    logic                   tick;
    logic [VAL_W-1:0]       value;
    logic [31:0]            sample_word;
    logic                   fifo_full;
    logic                   pop;

    // Tick generation and per-tick state advance.
    always_comb begin
        en_d   = ctrl_enable;
        cnt_d  = cnt_q;
        ch_d   = ch_q;
        seq_d  = seq_q;
        ramp_d = ramp_q;
        lfsr_d = lfsr_q;
        tick   = 1'b0;
        if (!ctrl_enable) begin
            cnt_d = '0;
        end else if (!en_q) begin
            cnt_d  = '0;
            ch_d   = '0;
            seq_d  = '0;
            ramp_d = '0;
            lfsr_d = LFSR_SEED;
        end else if (cnt_q > ctrl_div) begin
            // Divider shrunk below the running count: realign without a tick.
            cnt_d = '0;
        end else if (cnt_q == ctrl_div) begin
            tick   = 1'b1;
            cnt_d  = '0;
            ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            seq_d  = seq_q + 1'b1;
            ramp_d = ramp_q + ctrl_step;
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (ctrl_mode)
            MODE_LFSR:  value = lfsr_q;
            MODE_CONST: value = ctrl_const;
            default:    value = ramp_q;
        endcase
        sample_word                   = '0;
        sample_word[CH_LSB +: CH_W]   = ch_q;
        sample_word[SEQ_LSB +: SEQ_W] = seq_q;
        sample_word[VAL_LSB +: VAL_W] = value;
    end

    axis_fifo2 #(
        .W (32)
    ) u_fifo (
        .clk           (aclk),
        .rst_n         (aresetn),
        .push          (tick),
        .push_data     (sample_word),
        .full          (fifo_full),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    assign pop = m_axis_tvalid && m_axis_tready;

    always_comb begin
        sent_d = sent_q;
        drop_d = drop_q;
        if (ctrl_clr) begin
            sent_d = '0;
            drop_d = '0;
        end else begin
            if (pop && (sent_q != '1)) begin
                sent_d = sent_q + 1'b1;
            end
            if (tick && fifo_full && !pop && (drop_q != '1)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    assign stat_sent = sent_q;
    assign stat_drop = drop_q;
    assign stat_busy = ctrl_enable || m_axis_tvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q   <= 1'b0;
            cnt_q  <= '0;
            ch_q   <= '0;
            seq_q  <= '0;
            ramp_q <= '0;
            lfsr_q <= LFSR_SEED;
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            ch_q   <= ch_d;
            seq_q  <= seq_d;
            ramp_q <= ramp_d;
            lfsr_q <= lfsr_d;
            sent_q <= sent_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_adc_sample_src.sv
// tb/tb_adc_sample_src.sv - scoreboard bench for adc_sample_src
module tb_adc_sample_src;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctrl_enable;
    logic [1:0]  ctrl_mode;
    logic [15:0] ctrl_div;
    logic [15:0] ctrl_step;
    logic [15:0] ctrl_const;
    logic        ctrl_clr;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] stat_sent;
    logic [31:0] stat_drop;
    logic        stat_busy;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    time         ts [$];
    logic [31:0] exp_w;

    always #5 aclk = ~aclk;

    adc_sample_src #(
        .C_DIV_WIDTH (16),
        .C_NUM_CH    (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ctrl_enable   (ctrl_enable),
        .ctrl_mode     (ctrl_mode),
        .ctrl_div      (ctrl_div),
        .ctrl_step     (ctrl_step),
        .ctrl_const    (ctrl_const),
        .ctrl_clr      (ctrl_clr),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .stat_sent     (stat_sent),
        .stat_drop     (stat_drop),
        .stat_busy     (stat_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0_pending", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_intervals(input string name, input int n, input int period);
        if (ts.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_count actual=%0d required=%0d", name, ts.size(), n);
        end else begin
            for (int i = 1; i < n; i++) begin
                chk(name, 32'(ts[i] - ts[i-1]), 32'(period));
            end
        end
    endtask

    // Monitor: every handshake must match the oldest expected word.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            ts.push_back($time);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=0x%08h required=none", m_axis_tdata);
            end else begin
                exp_w = sb.pop_front();
                chk("sample", m_axis_tdata, exp_w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        ctrl_enable   = 1'b0;
        ctrl_mode     = 2'd0;
        ctrl_div      = 16'd0;
        ctrl_step     = 16'd0;
        ctrl_const    = 16'd0;
        ctrl_clr      = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) step();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_sent",   stat_sent, 32'd0);
        chk("rst_drop",   stat_drop, 32'd0);
        chk("rst_busy",   32'(stat_busy), 32'd0);
        aresetn = 1'b1;
        step();

        // Ramp, div=3, step=5, no backpressure.
        ts.delete();
        ctrl_mode = 2'd0; ctrl_div = 16'd3; ctrl_step = 16'd5; m_axis_tready = 1'b1;
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h1001_0005);
        sb.push_back(32'h2002_000A);
        sb.push_back(32'h3003_000F);
        sb.push_back(32'h0004_0014);
        ctrl_enable = 1'b1;
        wait_drain(40, "ramp");
        ctrl_enable = 1'b0;
        step();
        chk("ramp_sent", stat_sent, 32'd5);
        chk("ramp_drop", stat_drop, 32'd0);
        chk_intervals("ramp_period", 5, 40);

        // LFSR, div=0: one sample per cycle.
        ts.delete();
        ctrl_mode = 2'd1; ctrl_div = 16'd0;
        sb.push_back(32'h0000_ACE1);
        sb.push_back(32'h1001_59C3);
        sb.push_back(32'h2002_B387);
        sb.push_back(32'h3003_670F);
        ctrl_enable = 1'b1;
        repeat (5) step();
        ctrl_enable = 1'b0;
        wait_drain(10, "lfsr");
        chk_intervals("lfsr_period", 4, 10);

        // Backpressure for 10 ticks, then a pop coinciding with a tick while full.
        ctrl_mode = 2'd0; ctrl_div = 16'd0; ctrl_step = 16'd1; m_axis_tready = 1'b0;
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h1001_0001);
        sb.push_back(32'h200A_000A);
        ctrl_enable = 1'b1;
        repeat (6) step();
        chk("bp_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("bp_head_data",   m_axis_tdata, 32'h0000_0000);
        repeat (5) step();
        chk("bp_drop", stat_drop, 32'd8);
        m_axis_tready = 1'b1;
        step();
        ctrl_enable = 1'b0;
        step();
        chk("full_pop_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("full_pop_nodrop", stat_drop, 32'd8);
        wait_drain(10, "bp");
        step();
        chk("bp_sent", stat_sent, 32'd12);

        // Disable mid-run, drain under clear, then re-enable.
        ctrl_mode = 2'd0; ctrl_div = 16'd1; ctrl_step = 16'd3; m_axis_tready = 1'b0;
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h1001_0003);
        ctrl_enable = 1'b1;
        repeat (6) step();
        ctrl_enable = 1'b0;
        step();
        chk("drain_busy", 32'(stat_busy), 32'd1);
        chk("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        ctrl_clr = 1'b1;
        step();
        ctrl_clr = 1'b0;
        chk("clr_sent", stat_sent, 32'd0);
        chk("clr_drop", stat_drop, 32'd0);
        step();
        chk("after_clr_sent", stat_sent, 32'd1);
        chk("idle_busy", 32'(stat_busy), 32'd0);
        wait_drain(5, "drain");
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h1001_0003);
        ctrl_enable = 1'b1;
        repeat (6) step();
        ctrl_enable = 1'b0;
        wait_drain(10, "reenable");
        step();
        chk("reenable_sent", stat_sent, 32'd3);

        // Async reset while samples are buffered.
        ctrl_mode = 2'd2; ctrl_const = 16'h1234; ctrl_div = 16'd0; m_axis_tready = 1'b0;
        ctrl_enable = 1'b1;
        repeat (3) step();
        chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        ctrl_enable = 1'b0;
        #1;
        chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_sent",   stat_sent, 32'd0);
        chk("arst_drop",   stat_drop, 32'd0);
        chk("arst_busy",   32'(stat_busy), 32'd0);
        repeat (2) step();
        aresetn = 1'b1;
        step();
        m_axis_tready = 1'b1;
        sb.push_back(32'h0000_1234);
        ctrl_enable = 1'b1;
        repeat (2) step();
        ctrl_enable = 1'b0;
        wait_drain(10, "post_rst");
        step();
        chk("post_rst_sent", stat_sent, 32'd1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
